// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: the transmitter state type, the parity-mode
// encodings and a parity helper.
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_tx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Parity bit that makes the ones-count over data+parity even (EVEN) or
   // odd (ODD). Unused character bits must be zero.
   function automatic logic parity_bit(input logic [8:0] bits, input int mode);
      logic w_xor;
      w_xor = ^bits;
      return (mode == PARITY_ODD) ? ~w_xor : w_xor;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Character buffer placed in front of the UART serialiser. Pointers wrap
// modulo DEPTH (a power of two); a push while full is accepted when a pop
// happens in the same cycle. Flags are registered.
//
// Ports
//   clock    rising-edge clock
//   reset    synchronous, active-high reset (empties the buffer)
//   i_push   write i_data this cycle
//   i_data   character to store
//   i_pop    consume the oldest character this cycle
//   o_data   oldest stored character (valid while !o_empty)
//   o_full   all DEPTH entries occupied
//   o_empty  no entries occupied
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_push_ok;
   logic             w_pop_ok;
   logic [CNT_W-1:0] w_count_next;

   assign w_pop_ok  = i_pop && !r_empty;
   assign w_push_ok = i_push && (!r_full || w_pop_ok);

   always_comb begin
      // NOTE: assign a default first so every path drives the signal; a
      // missing branch would otherwise infer a latch.
      w_count_next = r_count;
      if (w_push_ok && !w_pop_ok)
         w_count_next = r_count + CNT_W'(1);
      else if (!w_push_ok && w_pop_ok)
         w_count_next = r_count - CNT_W'(1);
   end

   // NOTE: the storage array has no reset; occupancy is defined solely by
   // the pointers and count, which keeps the array mappable to plain RAM.
   always_ff @(posedge clock) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_next;
         r_full  <= (w_count_next == FULL_COUNT);
         r_empty <= (w_count_next == '0);
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, STOP_BITS stop bits. Each bit lasts
// CLKS_PER_BIT = CLOCK_RATE_HZ / BAUD_RATE clocks.
//
// Build option: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry buffer
// (uart_tx_fifo) in front of the serialiser; ready then means "not full".
// Without it, ready is high only in IDLE and in the final cycle of the last
// stop bit, so a held valid produces gap-free back-to-back frames.
//
// Ports
//   clock  rising-edge clock
//   reset  synchronous, active-high; aborts any frame in progress
//   valid  upstream character available
//   ready  block accepts a character this cycle
//   data   character, captured on the valid && ready edge
//   tx     serial line, idle high
//   busy   frame on the line or character buffered
// ---------------------------------------------------------------------------
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE_HZ = 100_000_000,
   parameter int BAUD_RATE     = 9_600,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 valid,
   output logic                 ready,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = CLOCK_RATE_HZ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [3:0]       LAST_DATA    = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP    = 4'(STOP_BITS - 1);

   // Elaboration-time parameter checks.
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx_cfg: CLOCK_RATE_HZ / BAUD_RATE must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
   end

   uart_tx_state_t       r_state;
   logic [CNT_W-1:0]     r_clk_cnt;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_tx;
   logic                 r_busy;
   // High exactly when the serialiser can load a character at the next edge:
   // in IDLE and in the final cycle of the last stop bit.
   logic                 r_ser_ready;

   logic                 w_bit_end;
   logic                 w_take;
   logic [DATA_BITS-1:0] w_char;

   assign w_bit_end = (r_clk_cnt == LAST_CNT);

`ifdef UART_TX_FIFO_EN
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [DATA_BITS-1:0] w_fifo_data;
   logic                 w_push;
   logic                 r_run;

   assign w_push = valid && ready;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (data),
      .i_pop   (w_take),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Holds ready low while reset is applied even though the FIFO is empty.
   always_ff @(posedge clock) begin
      if (reset) r_run <= 1'b0;
      else       r_run <= 1'b1;
   end

   assign w_take = r_ser_ready && !w_fifo_empty;
   assign w_char = w_fifo_data;
   assign ready  = r_run && !w_fifo_full;
   assign busy   = r_busy || !w_fifo_empty;
`else
   assign w_take = valid && r_ser_ready;
   assign w_char = data;
   assign ready  = r_ser_ready;
   assign busy   = r_busy;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_clk_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_parity    <= 1'b0;
         r_tx        <= 1'b1;
         r_busy      <= 1'b0;
         r_ser_ready <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_take) begin
                  r_state     <= S_START;
                  r_shift     <= w_char;
                  r_parity    <= parity_bit(9'(w_char), PARITY);
                  r_clk_cnt   <= '0;
                  r_tx        <= 1'b0;
                  r_busy      <= 1'b1;
                  r_ser_ready <= 1'b0;
               end else begin
                  r_busy      <= 1'b0;
                  r_ser_ready <= 1'b1;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_clk_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_tx      <= r_shift[0];
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_bit_cnt == LAST_DATA) begin
                     r_bit_cnt <= '0;
                     if (PARITY != PARITY_NONE) begin
                        r_state <= S_PARITY;
                        r_tx    <= r_parity;
                     end else begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     // Next bit is shift[1] before the shift takes effect.
                     r_bit_cnt <= r_bit_cnt + 4'(1);
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end

            S_PARITY: begin
               if (w_bit_end) begin
                  r_state   <= S_STOP;
                  r_clk_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_tx      <= 1'b1;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_bit_cnt == LAST_STOP) begin
                     r_bit_cnt <= '0;
                     if (w_take) begin
                        // Next character waiting: start bit follows directly.
                        r_state     <= S_START;
                        r_shift     <= w_char;
                        r_parity    <= parity_bit(9'(w_char), PARITY);
                        r_tx        <= 1'b0;
                        r_ser_ready <= 1'b0;
                     end else begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'(1);
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                  // Raise ready for the final cycle of the last stop bit.
                  if (r_bit_cnt == LAST_STOP && r_clk_cnt == PRE_LAST_CNT)
                     r_ser_ready <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign tx = r_tx;

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLOCK_RATE_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9_600, line bit rate in bits/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, character width, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop-bit count, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, buffer entries (power of two, >=2), used only when UART_TX_FIFO_EN is defined.
REQ-007 SHALL have port clock, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-009 SHALL have port valid, input, 1, upstream character available.
REQ-010 SHALL have port ready, output, 1, block accepts a character this cycle.
REQ-011 SHALL have port data, input, DATA_BITS, character to send.
REQ-012 SHALL have port tx, output, 1, serial line, idle high.
REQ-013 SHALL have port busy, output, 1, high while any frame bit is on the line or a character is buffered.

Function
REQ-014 SHALL transfer a character on every rising edge where valid && ready are both high; data is captured at that edge and later data changes have no effect.
REQ-015 SHALL hold each line bit for exactly CLKS_PER_BIT = CLOCK_RATE_HZ / BAUD_RATE clock cycles (integer truncation).
REQ-016 SHALL send frames as: start bit (0), DATA_BITS data bits LSB first, parity bit if PARITY!=0, STOP_BITS stop bits (1).
REQ-017 SHALL compute parity so the total number of ones over data+parity is even for PARITY=1 and odd for PARITY=2.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP; transitions: IDLE->START on character available; START->DATA after CLKS_PER_BIT; DATA->PARITY (or STOP when PARITY=0) after the last data bit; PARITY->STOP; STOP->START if another character is available at the end of the last stop bit, else STOP->IDLE.
REQ-019 SHALL drive tx low on the cycle immediately after the accepting edge when the block is idle (1-cycle latency).
REQ-020 SHALL send back-to-back frames with no idle gap when a next character is available at stop-bit end.
REQ-021 SHALL, without the FIFO, drive ready high only in IDLE and in the final cycle of the last stop bit.
REQ-022 SHALL keep tx high in IDLE.
REQ-023 SHALL deassert busy on the first IDLE cycle after the last stop bit.

Reset
REQ-024 SHALL, on reset, set tx=1, ready=0, busy=0, state=IDLE, bit and cycle counters to 0, FIFO empty.
REQ-025 SHALL set ready=1 on the first cycle after reset deasserts.
REQ-026 SHALL abort a frame in progress when reset is asserted mid-frame; tx returns high on the next edge and the partial character is discarded.

Configuration
REQ-027 SHALL, when UART_TX_FIFO_EN is defined, insert a FIFO_DEPTH-entry FIFO before the serialiser: ready = !full; the serialiser draws from the FIFO; a simultaneous push and pop when full is allowed; pointers wrap modulo FIFO_DEPTH.
REQ-028 SHALL, when UART_TX_FIFO_EN is undefined, contain no FIFO storage and behave as REQ-021.

Structure
REQ-029 SHALL take the state enum type uart_tx_state_t and the parity-mode constants (PARITY_NONE/EVEN/ODD) from shared package uart_pkg.
REQ-030 SHALL place the FIFO in one sub-module uart_tx_fifo, instantiated only under UART_TX_FIFO_EN.
REQ-031 SHALL fail elaboration for DATA_BITS outside 5..9, STOP_BITS not 1 or 2, PARITY>2, or CLKS_PER_BIT<2.

Verification (CLOCK_RATE_HZ=16, BAUD_RATE=1, so CLKS_PER_BIT=16)
REQ-032 SHALL cover: 8N1, send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each for 16 cycles; busy low 161 cycles after accept.
REQ-033 SHALL cover: DATA_BITS=7, PARITY=1, send 0x03 -> parity bit 0; PARITY=2 -> parity bit 1.
REQ-034 SHALL cover: STOP_BITS=2, 0xA5 then 0x3C held valid -> 32 high cycles between frames, no extra idle, second start immediately after.
REQ-035 SHALL cover: reset pulsed at cycle 40 of a frame -> tx=1 the next cycle, ready=1 the cycle after reset deasserts, no residual bits.
REQ-036 SHALL cover: UART_TX_FIFO_EN, FIFO_DEPTH=4, push 6 characters with valid held -> ready drops after 5 accepts (1 in serialiser, 4 buffered), all 6 appear in order on tx.
